// File: rtl/simon_128256.sv
// SIMON 128/256 block cipher core: iterative, one round per clock, with an
// on-chip round-key register file filled by a one-key-per-cycle expander.
module simon_128256 #(
    parameter int N  = 64,
    parameter int M  = 4,
    parameter int T  = 72,
    parameter int Co = 7
) (
    input  logic                 clk,
    input  logic                 nR,
    input  logic                 newKey,
    input  logic [M-1:0][N-1:0]  key,
    input  logic                 newData,
    input  logic                 enc_dec,
    input  logic [2*N-1:0]       plain,
    input  logic                 readData,
    output logic                 ldKey,
    output logic                 doneKey,
    output logic                 ldData,
    output logic                 doneData,
    output logic [2*N-1:0]       cipher
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_KEXP = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    // z4 constant sequence; index 0 of the sequence is the leftmost (MSB) bit
    localparam logic [61:0] Z4 =
        62'b11010001111001101011011000100000010111000011001010010011101111;

    localparam logic [Co-1:0] LAST  = Co'(T - 1);
    localparam logic [Co-1:0] FIRST = Co'(M);

    logic [1:0]    state;
    logic [N-1:0]  rk [T];
    logic [Co-1:0] kcnt;
    logic [Co-1:0] rcnt;
    logic [5:0]    zidx;
    logic [N-1:0]  x_q;
    logic [N-1:0]  y_q;
    logic          dir_q;

    logic          key_cap;
    logic          data_cap;
    logic [N-1:0]  ks_a;
    logic [N-1:0]  ks_t;
    logic [N-1:0]  ks_new;
    logic          zbit;
    logic [N-1:0]  rkey;
    logic [N-1:0]  nx;
    logic [N-1:0]  ny;

    function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int unsigned s);
        rol = (v << s) | (v >> (N - s));
    endfunction

    function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int unsigned s);
        ror = (v >> s) | (v << (N - s));
    endfunction

    function automatic logic [N-1:0] f(input logic [N-1:0] v);
        f = (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    // Key capture wins over data capture; both wait for any pending result to be read.
    always_comb begin
        key_cap  = (state == S_IDLE) && newKey && !ldKey && !doneData;
        data_cap = (state == S_IDLE) && !key_cap && newData && doneKey
                   && !doneData && !ldData;
    end

    always_comb begin
        zbit   = Z4[6'd61 - zidx];
        ks_a   = ror(rk[kcnt - Co'(1)], 3) ^ rk[kcnt - Co'(3)];
        ks_t   = ks_a ^ ror(ks_a, 1);
        ks_new = ~rk[kcnt - Co'(4)] ^ ks_t ^ {{(N-1){1'b0}}, zbit} ^ N'(3);
    end

    // Decryption walks the schedule backwards from the last round key.
    always_comb begin
        rkey = rk[dir_q ? rcnt : (LAST - rcnt)];
        if (dir_q) begin
            nx = y_q ^ f(x_q) ^ rkey;
            ny = x_q;
        end else begin
            nx = y_q;
            ny = x_q ^ f(y_q) ^ rkey;
        end
    end

    always_ff @(posedge clk) begin
        if (!nR) begin
            if (key_cap) begin
                for (int i = 0; i < M; i++) begin
                    rk[i] <= key[i];
                end
            end else if (state == S_KEXP) begin
                rk[kcnt] <= ks_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (nR) begin
            state    <= S_IDLE;
            ldKey    <= 1'b0;
            doneKey  <= 1'b0;
            ldData   <= 1'b0;
            doneData <= 1'b0;
            cipher   <= '0;
            kcnt     <= '0;
            rcnt     <= '0;
            zidx     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            dir_q    <= 1'b0;
        end else begin
            if (ldKey && !newKey) begin
                ldKey <= 1'b0;
            end
            if (ldData && !newData) begin
                ldData <= 1'b0;
            end
            if (doneData && readData) begin
                doneData <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (key_cap) begin
                        state   <= S_KEXP;
                        ldKey   <= 1'b1;
                        doneKey <= 1'b0;
                        kcnt    <= FIRST;
                        zidx    <= '0;
                    end else if (data_cap) begin
                        state  <= S_DATA;
                        ldData <= 1'b1;
                        x_q    <= plain[2*N-1:N];
                        y_q    <= plain[N-1:0];
                        dir_q  <= enc_dec;
                        rcnt   <= '0;
                    end
                end
                S_KEXP: begin
                    kcnt <= kcnt + Co'(1);
                    zidx <= (zidx == 6'd61) ? 6'd0 : zidx + 6'd1;
                    if (kcnt == LAST) begin
                        state   <= S_IDLE;
                        doneKey <= 1'b1;
                        kcnt    <= '0;
                    end
                end
                S_DATA: begin
                    x_q  <= nx;
                    y_q  <= ny;
                    rcnt <= rcnt + Co'(1);
                    // Result is published on the edge that completes the last round.
                    if (rcnt == LAST) begin
                        state    <= S_IDLE;
                        cipher   <= {nx, ny};
                        doneData <= 1'b1;
                        rcnt     <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_128256.sv
// Directed bench for simon_128256: reference vectors, handshake ordering,
// result hold, held-request behaviour and mid-operation reset.
module tb_simon_128256;

    localparam logic [255:0] KEY = 256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] PT  = 128'h74206e69206d6f6f_6d69732061207369;
    localparam logic [127:0] CT  = 128'h8d2b5579afc8a3a0_3bf72a87efe7b868;

    logic            clk = 1'b0;
    logic            nR;
    logic            newKey;
    logic [3:0][63:0] key;
    logic            newData;
    logic            enc_dec;
    logic [127:0]    plain;
    logic            readData;
    logic            ldKey;
    logic            doneKey;
    logic            ldData;
    logic            doneData;
    logic [127:0]    cipher;

    int passed = 0;
    int total  = 0;
    int cyc;
    logic flag;
    logic [127:0] held;

    simon_128256 dut (
        .clk      (clk),
        .nR       (nR),
        .newKey   (newKey),
        .key      (key),
        .newData  (newData),
        .enc_dec  (enc_dec),
        .plain    (plain),
        .readData (readData),
        .ldKey    (ldKey),
        .doneKey  (doneKey),
        .ldData   (ldData),
        .doneData (doneData),
        .cipher   (cipher)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic nk, input logic nd, input logic rd);
        newKey   = nk;
        newData  = nd;
        readData = rd;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic waitDoneKey(output int n, output logic sawLd);
        n = 0;
        sawLd = 1'b0;
        while (!doneKey && n < 200) begin
            tick();
            n++;
            if (ldData) sawLd = 1'b1;
        end
    endtask

    task automatic waitDoneData(output int n);
        n = 0;
        while (!doneData && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        nR = 1'b1;
        key = KEY;
        plain = PT;
        enc_dec = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        tick();
        tick();
        checkOutput("rst_flags", {124'd0, ldKey, doneKey, ldData, doneData}, 128'd0);
        checkOutput("rst_cipher", cipher, 128'd0);
        nR = 1'b0;

        // Key and data requested together: key goes first
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("both_ldKey", {126'd0, ldKey, ldData}, 128'd2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitDoneKey(cyc, flag);
        checkOutput("keyexp_cycles", 128'(cyc), 128'd68);
        checkOutput("no_ld_before_key", {127'd0, flag}, 128'd0);
        tick();
        checkOutput("ldData_after_key", {127'd0, ldData}, 128'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitDoneData(cyc);
        checkOutput("enc_cycles", 128'(cyc), 128'd72);
        checkOutput("enc_cipher", cipher, CT);
        checkOutput("ldData_cleared", {127'd0, ldData}, 128'd0);

        // Result held while unread; a data request meanwhile is not taken
        held = cipher;
        flag = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cipher !== held || !doneData || ldData) flag = 1'b1;
        end
        checkOutput("hold_stable", {127'd0, flag}, 128'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("read_clears", {127'd0, doneData}, 128'd0);
        checkOutput("cipher_kept", cipher, CT);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Decrypt with the same schedule
        plain = CT;
        enc_dec = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("dec_ldData", {127'd0, ldData}, 128'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitDoneData(cyc);
        checkOutput("dec_plain", cipher, PT);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);

        // newData held high: only one block
        plain = PT;
        enc_dec = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitDoneData(cyc);
        checkOutput("held_cipher", cipher, CT);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0);
        flag = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (doneData) flag = 1'b1;
        end
        checkOutput("held_no_restart", {127'd0, flag}, 128'd0);
        checkOutput("held_ldData", {127'd0, ldData}, 128'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("held_release", {127'd0, ldData}, 128'd0);

        // Reset in the middle of an encryption
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (10) tick();
        nR = 1'b1;
        tick();
        nR = 1'b0;
        checkOutput("midrst_flags", {124'd0, ldKey, doneKey, ldData, doneData}, 128'd0);
        checkOutput("midrst_cipher", cipher, 128'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        flag = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (ldData || doneData) flag = 1'b1;
        end
        checkOutput("nokey_ignored", {127'd0, flag}, 128'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("reload_ldKey", {127'd0, ldKey}, 128'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitDoneKey(cyc, flag);
        checkOutput("reload_cycles", 128'(cyc), 128'd68);
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitDoneData(cyc);
        checkOutput("reload_cipher", cipher, CT);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
